kernel_bank_loader: RTL and testbench

// - Double-buffered, parametrised coefficient store for the CNN datapath. Replaces per-layer kernel shift-chains and fixed-width load-done counters.
// - Streams FP32 kernel/weight words serially into a shadow set, one bank at a time.
// - Copies all shadow banks to the active set on an atomic swap, so conv/perceptron stages read stable taps while the next set loads.

---
 rtl/kern_pkg.sv | 22 ++
 rtl/kernel_shadow_chain.sv | 54 +++++
 rtl/kernel_bank_loader.sv | 133 +++++++++++++
 tb/tb_kernel_bank_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kern_pkg.sv
// Shared definitions for the CNN coefficient store.
// Contents:
//   FP_W     - FP32 word width used by the kernel/weight datapath
//   KTAPS    - tap count of one 3x3 kernel
//   state_t  - loader FSM state encoding
//   flat_off - (bank, word) -> bit offset into a flattened tap vector
package kern_pkg;

  localparam int FP_W  = 32;
  localparam int KTAPS = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Bank b word k of a flattened store lives at [(b*depth + k)*dw +: dw].
  function automatic int flat_off(int bank, int word, int depth, int dw);
    return (bank * depth + word) * dw;
  endfunction

endpackage

// File: rtl/kernel_shadow_chain.sv
// One bank of the double-buffered coefficient store.
// Words shift serially into a shadow chain. After DEPTH shifts, shadow word 0
// holds the first word received. On copy_en the whole shadow chain is copied
// in parallel to the active register, which drives the taps.
// Ports:
//   clk      in  1         rising-edge clock
//   rst      in  1         synchronous, active-high reset
//   shift_en in  1         shift shift_in into the chain
//   shift_in in  DW        incoming coefficient word
//   copy_en  in  1         copy shadow -> active
//   active   out DEPTH*DW  active taps; word k at [k*DW +: DW]
module kernel_shadow_chain
  import kern_pkg::*;
#(
  parameter int DW    = FP_W,
  parameter int DEPTH = KTAPS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic [DW-1:0]       shift_in,
  input  logic                copy_en,
  output logic [DEPTH*DW-1:0] active
);

  logic [DW-1:0] shadow_q [DEPTH];
  logic [DW-1:0] active_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both word arrays are cleared on reset because the active taps must
      // read all-zero after reset; a storage array is normally left unreset.
      for (int k = 0; k < DEPTH; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      // New words enter at the top and move toward word 0, so the first word
      // received ends up in word 0 after DEPTH shifts.
      if (shift_en) begin
        for (int k = 0; k < DEPTH - 1; k++) shadow_q[k] <= shadow_q[k+1];
        shadow_q[DEPTH-1] <= shift_in;
      end
      if (copy_en) begin
        for (int k = 0; k < DEPTH; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign active[k*DW +: DW] = active_q[k];
  end

endmodule

// File: rtl/kernel_bank_loader.sv
// Double-buffered, parametrised coefficient store for the CNN datapath.
// Streams words serially into one shadow bank at a time; an atomic swap copies
// every shadow bank to the active set so downstream stages read stable taps
// while the next set loads.
// Ports:
//   clk         in  1                   rising-edge clock
//   rst         in  1                   synchronous, active-high reset
//   load_start  in  1                   begin loading bank load_bank
//   load_bank   in  BANK_W              bank index, sampled with load_start
//   load_valid  in  1                   load_data valid
//   load_data   in  DW                  coefficient word
//   load_ready  out 1                   word accepted on load_valid&&load_ready
//   load_done   out 1                   pulse: selected bank holds DEPTH words
//   shadow_full out NUM_BANKS           per-bank shadow complete flags
//   swap_req    in  1                   request shadow -> active copy
//   swap_ack    out 1                   pulse: copy performed
//   swap_err    out 1                   pulse: swap refused
//   kern_active out NUM_BANKS*DEPTH*DW  active taps, bank b word k at
//                                       [(b*DEPTH+k)*DW +: DW]
module kernel_bank_loader
  import kern_pkg::*;
#(
  parameter  int DW        = FP_W,
  parameter  int DEPTH     = KTAPS,
  parameter  int NUM_BANKS = 10,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [BANK_W-1:0]             load_bank,
  input  logic                          load_valid,
  input  logic [DW-1:0]                 load_data,
  output logic                          load_ready,
  output logic                          load_done,
  output logic [NUM_BANKS-1:0]          shadow_full,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          swap_err,
  output logic [NUM_BANKS*DEPTH*DW-1:0] kern_active
);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [BANK_W:0]   NB_C    = (BANK_W + 1)'(NUM_BANKS);

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      count_q;
  logic [BANK_W-1:0]     bank_q;
  logic [NUM_BANKS-1:0]  bank_sel, start_sel;
  logic                  start_ok, accept, last_accept, swap_ok;

  // Out-of-range bank indices are ignored entirely.
  assign start_ok    = load_start && ({1'b0, load_bank} < NB_C);
  assign load_ready  = (state_q == ST_LOAD) && (count_q < DEPTH_C);
  // A word presented alongside a (re)start is dropped so the new bank begins clean.
  assign accept      = load_ready && load_valid && !start_ok;
  assign last_accept = accept && (count_q == LAST_C);
  assign swap_ok     = swap_req && (state_q == ST_IDLE) && (&shadow_full) && !load_start;

  always_comb begin
    bank_sel  = '0;
    start_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b]  = (bank_q == BANK_W'(b));
      start_sel[b] = (load_bank == BANK_W'(b));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    // NOTE: state_n gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_n = ST_LOAD;
      ST_LOAD: begin
        if (start_ok)         state_n = ST_LOAD;
        else if (last_accept) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      bank_q      <= '0;
      shadow_full <= '0;
      load_done   <= 1'b0;
      swap_ack    <= 1'b0;
      swap_err    <= 1'b0;
    end else begin
      load_done <= last_accept;
      swap_ack  <= swap_ok;
      swap_err  <= swap_req && !swap_ok;

      if (start_ok) begin
        bank_q  <= load_bank;
        count_q <= '0;
      end else if (accept) begin
        // Saturates at DEPTH: accept is gated by count_q < DEPTH.
        count_q <= count_q + CNT_W'(1);
      end

      if (swap_ok) shadow_full <= '0;
      else shadow_full <= (shadow_full & ~(start_ok ? start_sel : '0))
                        | (last_accept ? bank_sel : '0);
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    kernel_shadow_chain #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_chain (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept && bank_sel[b]),
      .shift_in (load_data),
      .copy_en  (swap_ok),
      .active   (kern_active[flat_off(b, 0, DEPTH, DW) +: DEPTH*DW])
    );
  end

endmodule

// File: tb/tb_kernel_bank_loader.sv
// Directed bench for kernel_bank_loader: a DEPTH=9 / 2-bank instance covers
// load, swap, backpressure and abort; a DEPTH=900 / 1-bank instance covers the
// long counter and mid-load reset.
module tb_kernel_bank_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---- small instance ----
  logic             a_rst = 1'b1, a_load_start = 1'b0, a_load_valid = 1'b0, a_swap_req = 1'b0;
  logic [0:0]       a_load_bank = '0;
  logic [31:0]      a_load_data = '0;
  logic             a_load_ready, a_load_done, a_swap_ack, a_swap_err;
  logic [1:0]       a_shadow_full;
  logic [2*9*32-1:0] a_kern;

  kernel_bank_loader #(.DW(32), .DEPTH(9), .NUM_BANKS(2)) u_a (
    .clk(clk), .rst(a_rst), .load_start(a_load_start), .load_bank(a_load_bank),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_ready(a_load_ready),
    .load_done(a_load_done), .shadow_full(a_shadow_full), .swap_req(a_swap_req),
    .swap_ack(a_swap_ack), .swap_err(a_swap_err), .kern_active(a_kern)
  );

  // ---- large-depth instance ----
  logic             b_rst = 1'b1, b_load_start = 1'b0, b_load_valid = 1'b0, b_swap_req = 1'b0;
  logic [0:0]       b_load_bank = '0;
  logic [31:0]      b_load_data = '0;
  logic             b_load_ready, b_load_done, b_swap_ack, b_swap_err;
  logic [0:0]       b_shadow_full;
  logic [900*32-1:0] b_kern;

  kernel_bank_loader #(.DW(32), .DEPTH(900), .NUM_BANKS(1)) u_b (
    .clk(clk), .rst(b_rst), .load_start(b_load_start), .load_bank(b_load_bank),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
    .load_done(b_load_done), .shadow_full(b_shadow_full), .swap_req(b_swap_req),
    .swap_ack(b_swap_ack), .swap_err(b_swap_err), .kern_active(b_kern)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] a_word(int b, int k);
    return a_kern[(b*9 + k)*32 +: 32];
  endfunction

  task automatic a_start(input logic [0:0] bank);
    a_load_start = 1'b1;
    a_load_bank  = bank;
    tick();
    a_load_start = 1'b0;
  endtask

  // Streams n words base+0.. into the loading bank; gaps randomises load_valid.
  // Returns the number of load_done pulses seen while streaming.
  task automatic a_stream(input int n, input logic [31:0] base, input bit gaps,
                          output int dn);
    int acc = 0;
    int budget = 400;
    bit take;
    dn = 0;
    while (acc < n && budget > 0) begin
      a_load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a_load_data  = base + 32'(acc);
      take = a_load_valid && a_load_ready;
      tick();
      if (take) acc++;
      dn += int'(a_load_done);
      budget--;
    end
    a_load_valid = 1'b0;
    if (budget == 0) check("stream_timeout", 32'(acc), 32'(n));
  endtask

  // Full bank load with completion checks; afterwards holds an extra valid word.
  task automatic a_load(input logic [0:0] bank, input logic [31:0] base, input bit gaps,
                        input string tag);
    int dn;
    a_start(bank);
    a_stream(9, base, gaps, dn);
    check({tag, "_done_now"}, 32'(a_load_done), 32'd1);
    check({tag, "_ready_low"}, 32'(a_load_ready), 32'd0);
    a_load_valid = 1'b1;
    a_load_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      dn += int'(a_load_done);
    end
    check({tag, "_ready_held_low"}, 32'(a_load_ready), 32'd0);
    a_load_valid = 1'b0;
    check({tag, "_done_once"}, 32'(dn), 32'd1);
  endtask

  task automatic a_swap();
    a_swap_req = 1'b1;
    tick();
    a_swap_req = 1'b0;
  endtask

  task automatic a_check_bank(input int b, input logic [31:0] base, input string tag);
    int errs = 0;
    for (int k = 0; k < 9; k++) if (a_word(b, k) !== base + 32'(k)) errs++;
    check(tag, 32'(errs), 32'd0);
    if (errs != 0) check({tag, "_w0"}, a_word(b, 0), base);
  endtask

  initial begin
    int dn;
    int acc;
    bit take;

    // ---------------- reset ----------------
    repeat (2) tick();
    check("rst_ready", 32'(a_load_ready), 32'd0);
    check("rst_done", 32'(a_load_done), 32'd0);
    check("rst_full", 32'(a_shadow_full), 32'd0);
    check("rst_ack", 32'(a_swap_ack), 32'd0);
    check("rst_err", 32'(a_swap_err), 32'd0);
    check("rst_active_zero", 32'(|a_kern), 32'd0);
    a_rst = 1'b0;
    tick();

    // ---------------- bank 0, then premature swap ----------------
    a_load(1'b0, 32'h3F80_0000, 1'b0, "ld0");
    check("full_after_b0", 32'(a_shadow_full), 32'b01);
    a_swap();
    check("early_swap_err", 32'(a_swap_err), 32'd1);
    check("early_swap_ack", 32'(a_swap_ack), 32'd0);
    check("early_swap_active", 32'(|a_kern), 32'd0);
    tick();
    check("err_pulse_one", 32'(a_swap_err), 32'd0);

    // ---------------- bank 1, then swap ----------------
    a_load(1'b1, 32'h4000_0000, 1'b0, "ld1");
    check("full_both", 32'(a_shadow_full), 32'b11);
    a_swap();
    check("swap_ack", 32'(a_swap_ack), 32'd1);
    check("swap_no_err", 32'(a_swap_err), 32'd0);
    check("swap_full_clr", 32'(a_shadow_full), 32'd0);
    a_check_bank(0, 32'h3F80_0000, "swap1_bank0");
    a_check_bank(1, 32'h4000_0000, "swap1_bank1");
    tick();
    check("ack_pulse_one", 32'(a_swap_ack), 32'd0);

    // ---------------- backpressure ----------------
    a_load(1'b0, 32'h4100_0000, 1'b1, "bp0");
    check("bp_active_stable", a_word(0, 0), 32'h3F80_0000);
    a_load(1'b1, 32'h4200_0000, 1'b1, "bp1");
    a_swap();
    check("bp_swap_ack", 32'(a_swap_ack), 32'd1);
    a_check_bank(0, 32'h4100_0000, "bp_bank0");
    a_check_bank(1, 32'h4200_0000, "bp_bank1");

    // ---------------- abort ----------------
    a_start(1'b0);
    a_stream(4, 32'h5000_0000, 1'b0, dn);
    // Restart onto bank 1 with a word presented in the same cycle: it must be dropped.
    a_load_start = 1'b1;
    a_load_bank  = 1'b1;
    a_load_valid = 1'b1;
    a_load_data  = 32'hBAD0_BAD0;
    tick();
    a_load_start = 1'b0;
    a_stream(9, 32'h4300_0000, 1'b0, dn);
    check("abort_done", 32'(a_load_done), 32'd1);
    a_load_valid = 1'b1;
    a_load_data  = 32'hDEAD_BEEF;
    tick();
    check("abort_10th_ready", 32'(a_load_ready), 32'd0);
    a_load_valid = 1'b0;
    check("abort_full", 32'(a_shadow_full), 32'b10);
    a_swap();
    check("abort_swap_err", 32'(a_swap_err), 32'd1);
    a_load(1'b0, 32'h4400_0000, 1'b0, "ld_after_abort");
    a_swap();
    check("abort_swap_ack", 32'(a_swap_ack), 32'd1);
    a_check_bank(0, 32'h4400_0000, "abort_bank0");
    a_check_bank(1, 32'h4300_0000, "abort_bank1");

    // ---------------- large depth ----------------
    b_rst = 1'b0;
    tick();
    // Bank 1 does not exist here: the start is ignored.
    b_load_start = 1'b1;
    b_load_bank  = 1'b1;
    tick();
    b_load_start = 1'b0;
    check("big_bad_bank_ready", 32'(b_load_ready), 32'd0);
    b_load_bank  = 1'b0;
    b_load_start = 1'b1;
    tick();
    b_load_start = 1'b0;
    acc = 0;
    dn  = 0;
    for (int i = 0; i < 1200 && acc < 900; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 32'h0000_1000 + 32'(acc);
      take = b_load_ready;
      tick();
      if (take) acc++;
      dn += int'(b_load_done);
      if (acc < 900 && b_load_done) check("big_early_done", 32'(acc), 32'd900);
    end
    b_load_valid = 1'b0;
    check("big_accepts", 32'(acc), 32'd900);
    check("big_done_at_900", 32'(b_load_done), 32'd1);
    check("big_ready_low", 32'(b_load_ready), 32'd0);
    check("big_full", 32'(b_shadow_full), 32'd1);
    b_swap_req = 1'b1;
    tick();
    b_swap_req = 1'b0;
    check("big_swap_ack", 32'(b_swap_ack), 32'd1);
    check("big_w0", b_kern[0 +: 32], 32'h0000_1000);
    check("big_w899", b_kern[899*32 +: 32], 32'h0000_1000 + 32'd899);

    // Reload, reset at word 450.
    b_load_start = 1'b1;
    tick();
    b_load_start = 1'b0;
    for (int i = 0; i < 450; i++) begin
      b_load_valid = 1'b1;
      b_load_data  = 32'h0000_2000 + 32'(i);
      tick();
    end
    b_rst = 1'b1;
    b_swap_req = 1'b1;
    tick();
    b_swap_req = 1'b0;
    b_load_valid = 1'b0;
    check("big_rst_ready", 32'(b_load_ready), 32'd0);
    check("big_rst_full", 32'(b_shadow_full), 32'd0);
    check("big_rst_done", 32'(b_load_done), 32'd0);
    check("big_rst_ack", 32'(b_swap_ack), 32'd0);
    check("big_rst_err", 32'(b_swap_err), 32'd0);
    check("big_rst_active_zero", 32'(|b_kern), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
